student_ss_analog_status_mon: RTL
=================================

Name: student_ss_analog_status_mon

Overview:
- Sits directly downstream of the analog student subsystem and consumes its four 32-bit status words (status_0..status_3).
- These words come from an analog/asynchronous domain. The block synchronises each word, applies a per-word stability filter, and latches accepted values.
- Per-word sticky change flags and an interrupt are maintained.
- The filtered values and flags are exposed to the SoC over a zero-wait-state APB slave.

Parameters:
- STABLE_CYCLES, 4: consecutive cycles a synchronised word must hold before acceptance; legal range 1..255.
- APB_AW, 12: APB address width.

Ports:
- clk_in  input  1  system clock.
- reset_int  input  1  asynchronous active-low reset.
- status_0_in  input  32  analog subsystem status word 0 (asynchronous).
- status_1_in  input  32  status word 1.
- status_2_in  input  32  status word 2.
- status_3_in  input  32  status word 3.
- PSEL  input  1  APB select.
- PENABLE  input  1  APB enable.
- PWRITE  input  1  APB write.
- PADDR  input  APB_AW  APB byte address.
- PWDATA  input  32  APB write data.
- PRDATA  output  32  APB read data.
- PREADY  output  1  always 1.
- PSLVERR  output  1  APB error.
- irq_out  output  1  level interrupt, registered.

Behaviour:
- Reset (reset_int=0, async): all sync flops, candidates and filtered words = 0; counters = 0; CHG = 0; IRQ_EN = 0; irq_out = 0; PRDATA = 0; PSLVERR = 0.
- Per-word pipeline: sync1 <= in, then sync2 <= sync1, then candidate/counter stage.
- Multi-bit synchronisation is safe only because of the stability filter. Words skewed across bits are rejected until the value settles.
- Filter rules:
  - If sync2 != candidate: candidate <= sync2, cnt <= 0.
  - Else if cnt < STABLE_CYCLES-1: cnt++.
  - Else (cnt saturated): if candidate != filtered, then filtered <= candidate and CHG[i] is set that same edge.
- Latency: input changes before edge E and then holds. Filtered word updates at edge E+2+STABLE_CYCLES (E+6 with default). CHG[i] becomes visible on the same edge.
- A glitch shorter than STABLE_CYCLES+1 cycles at sync2 never reaches filtered. Its CHG bit is not set.
- A value returning to the current filtered word after a glitch does not set CHG.
- Register map (word offsets; PADDR[1:0] ignored):
  - 0x00, 0x04, 0x08, 0x0C: STATUS0..3, RO, filtered words.
  - 0x10: CHG[3:0], W1C; bits 31:4 read 0.
  - 0x14: IRQ_EN[3:0], RW.
  - 0x18: RAW_EQ[3:0], RO; bit i = (sync2 == filtered) for word i.
- APB access:
  - Access phase is PSEL & PENABLE; PREADY is tied 1.
  - PRDATA and PSLVERR are driven combinationally during the access phase and are 0 otherwise.
- APB errors (PSLVERR=1 on the access cycle):
  - Read of an unmapped address returns PRDATA=0.
  - Write to an RO or unmapped address has no state change.
- Simultaneous W1C clear and hardware set of the same CHG bit: set wins, so the bit stays 1.
- irq_out <= |(CHG & IRQ_EN) is registered, so it lags the flag/enable change by one cycle.
- Writing IRQ_EN with a pending CHG asserts irq_out one cycle later.
- Reset mid-filter: all state returns to 0 immediately. The filter restarts from the synchronisers after reset release.

Decomposition:
- Package student_ss_analog_status_pkg holds:
  - NUM_STATUS=4.
  - Address offset localparams: ADDR_STATUS0..3, ADDR_CHG, ADDR_IRQ_EN, ADDR_RAW_EQ.
  - A typedef for the 32-bit status word.
- Sub-module student_ss_status_filter, instantiated 4x: 2-flop synchroniser, candidate, counter and filtered register. Outputs are filtered, a one-cycle accept_chg pulse, and raw_eq.
- The top level holds the APB decode, CHG/IRQ_EN registers and irq_out.

Test Plan:
- Reset, then read 0x00–0x18: STATUS=0, CHG=0, IRQ_EN=0, RAW_EQ=0xF, irq_out=0; read 0x20: PRDATA=0, PSLVERR=1.
- status_1_in=0x0000_0001 held from edge E: STATUS1 reads 0 at E+5, reads 0x1 at E+6; CHG=0x2; irq_out stays 0 while IRQ_EN=0.
- With IRQ_EN=0x2 set, pulse status_2_in=0xDEAD_BEEF for 3 cycles, then return to 0: STATUS2 stays 0, CHG bit2=0, irq_out=0.
- CHG=0x2 and IRQ_EN=0x2, irq_out=1; write 0x10 data 0x2: CHG=0 next cycle, irq_out=0 one cycle later. Repeat with the write coinciding with a new status_1 acceptance: CHG bit1 stays 1.
- Write 0x00 with 0x1234: PSLVERR=1 and STATUS0 unchanged. Assert reset_int=0 mid-filter: all outputs 0 asynchronously, no acceptance after release until STABLE_CYCLES+2 cycles.

Source files
------------

// File: rtl/student_ss_analog_status_pkg.sv
// Shared constants and types for the analog status monitor.
// Register offsets are byte addresses; the low two address bits are ignored.
package student_ss_analog_status_pkg;
  localparam int NUM_STATUS = 4;

  localparam logic [7:0] ADDR_STATUS0 = 8'h00;
  localparam logic [7:0] ADDR_STATUS1 = 8'h04;
  localparam logic [7:0] ADDR_STATUS2 = 8'h08;
  localparam logic [7:0] ADDR_STATUS3 = 8'h0C;
  localparam logic [7:0] ADDR_CHG     = 8'h10;
  localparam logic [7:0] ADDR_IRQ_EN  = 8'h14;
  localparam logic [7:0] ADDR_RAW_EQ  = 8'h18;

  typedef logic [31:0] status_word_t;
endpackage

// File: rtl/student_ss_status_filter.sv
// One status word: 2-flop synchroniser, stability filter and accepted-value register.
// accept_chg is combinational and marks the edge on which filtered takes a new value.
module student_ss_status_filter
  import student_ss_analog_status_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic        clk_in,
  input  logic        reset_int,
  input  logic [31:0] status_in,
  output logic [31:0] filtered,
  output logic        accept_chg,
  output logic        raw_eq
);
  localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES - 1);

  status_word_t sync1_q, sync1_d;
  status_word_t sync2_q, sync2_d;
  status_word_t cand_q, cand_d;
  status_word_t filt_q, filt_d;
  logic [7:0]   cnt_q, cnt_d;

  // Bit-skewed samples keep reloading the candidate, so only a settled word is accepted.
  always_comb begin
    sync1_d    = status_in;
    sync2_d    = sync1_q;
    cand_d     = cand_q;
    cnt_d      = cnt_q;
    filt_d     = filt_q;
    accept_chg = 1'b0;
    if (sync2_q != cand_q) begin
      cand_d = sync2_q;
      cnt_d  = '0;
    end else if (cnt_q < CNT_MAX) begin
      cnt_d = cnt_q + 8'd1;
    end else if (cand_q != filt_q) begin
      filt_d     = cand_q;
      accept_chg = 1'b1;
    end
  end

  always_ff @(posedge clk_in or negedge reset_int) begin
    if (!reset_int) begin
      sync1_q <= '0;
      sync2_q <= '0;
      cand_q  <= '0;
      cnt_q   <= '0;
      filt_q  <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      filt_q  <= filt_d;
    end
  end

  assign filtered = filt_q;
  assign raw_eq   = (sync2_q == filt_q);
endmodule

// File: rtl/student_ss_analog_status_mon.sv
// Filters four asynchronous status words and exposes them, sticky change flags and an
// interrupt over a zero-wait-state APB slave; PRDATA/PSLVERR are combinational in the access phase.
module student_ss_analog_status_mon
  import student_ss_analog_status_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int APB_AW        = 12
) (
  input  logic              clk_in,
  input  logic              reset_int,
  input  logic [31:0]       status_0_in,
  input  logic [31:0]       status_1_in,
  input  logic [31:0]       status_2_in,
  input  logic [31:0]       status_3_in,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [APB_AW-1:0] PADDR,
  input  logic [31:0]       PWDATA,
  output logic [31:0]       PRDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  output logic              irq_out
);
  status_word_t            stat_in [NUM_STATUS];
  status_word_t            filt    [NUM_STATUS];
  logic [NUM_STATUS-1:0]   accept;
  logic [NUM_STATUS-1:0]   raw_eq;
  logic [NUM_STATUS-1:0]   chg_q, chg_d;
  logic [NUM_STATUS-1:0]   irq_en_q, irq_en_d;
  logic                    irq_q, irq_d;

  logic [APB_AW-1:0]       addr_w;
  logic                    access, is_ro, is_rw, wr_chg, wr_en;
  logic [31:0]             rd_dat;
  logic                    unused_ok;

  assign stat_in[0] = status_0_in;
  assign stat_in[1] = status_1_in;
  assign stat_in[2] = status_2_in;
  assign stat_in[3] = status_3_in;

  for (genvar i = 0; i < NUM_STATUS; i++) begin : g_filt
    student_ss_status_filter #(.STABLE_CYCLES(STABLE_CYCLES)) u_filt (
      .clk_in     (clk_in),
      .reset_int  (reset_int),
      .status_in  (stat_in[i]),
      .filtered   (filt[i]),
      .accept_chg (accept[i]),
      .raw_eq     (raw_eq[i])
    );
  end

  always_comb begin
    addr_w = {PADDR[APB_AW-1:2], 2'b00};
    access = PSEL & PENABLE;
    rd_dat = '0;
    is_ro  = 1'b0;
    is_rw  = 1'b0;
    if (addr_w == APB_AW'(ADDR_STATUS0)) begin
      rd_dat = filt[0];
      is_ro  = 1'b1;
    end else if (addr_w == APB_AW'(ADDR_STATUS1)) begin
      rd_dat = filt[1];
      is_ro  = 1'b1;
    end else if (addr_w == APB_AW'(ADDR_STATUS2)) begin
      rd_dat = filt[2];
      is_ro  = 1'b1;
    end else if (addr_w == APB_AW'(ADDR_STATUS3)) begin
      rd_dat = filt[3];
      is_ro  = 1'b1;
    end else if (addr_w == APB_AW'(ADDR_CHG)) begin
      rd_dat = {{(32-NUM_STATUS){1'b0}}, chg_q};
      is_rw  = 1'b1;
    end else if (addr_w == APB_AW'(ADDR_IRQ_EN)) begin
      rd_dat = {{(32-NUM_STATUS){1'b0}}, irq_en_q};
      is_rw  = 1'b1;
    end else if (addr_w == APB_AW'(ADDR_RAW_EQ)) begin
      rd_dat = {{(32-NUM_STATUS){1'b0}}, raw_eq};
      is_ro  = 1'b1;
    end
    wr_chg  = access & PWRITE & (addr_w == APB_AW'(ADDR_CHG));
    wr_en   = access & PWRITE & (addr_w == APB_AW'(ADDR_IRQ_EN));
    PRDATA  = access ? rd_dat : '0;
    PSLVERR = access & (PWRITE ? ~is_rw : ~(is_ro | is_rw));
  end

  // A hardware set on the same edge as a W1C clear wins.
  always_comb begin
    chg_d    = (chg_q & ~(wr_chg ? PWDATA[NUM_STATUS-1:0] : '0)) | accept;
    irq_en_d = wr_en ? PWDATA[NUM_STATUS-1:0] : irq_en_q;
    irq_d    = |(chg_q & irq_en_q);
  end

  always_ff @(posedge clk_in or negedge reset_int) begin
    if (!reset_int) begin
      chg_q    <= '0;
      irq_en_q <= '0;
      irq_q    <= 1'b0;
    end else begin
      chg_q    <= chg_d;
      irq_en_q <= irq_en_d;
      irq_q    <= irq_d;
    end
  end

  assign PREADY    = 1'b1;
  assign irq_out   = irq_q;
  assign unused_ok = ^{PADDR[1:0], PWDATA[31:NUM_STATUS]};
endmodule
